// File: rtl/cache_lookup_ctrl.sv
// Read-only direct-mapped cache controller: single outstanding CPU word read, tag compare one
// cycle after the SRAM read, single-beat line refill on a miss, saturating hit/miss counters.
module cache_lookup_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 9,
    parameter int OFFSET_W = 6,
    parameter int LINE_W   = 512,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_data_o,
    output logic                sram_rden_o,
    output logic [INDEX_W-1:0]  sram_raddr_o,
    input  logic [TAG_W:0]      sram_rtag_i,
    input  logic [LINE_W-1:0]   sram_rdata_i,
    output logic                sram_wren_o,
    output logic [INDEX_W-1:0]  sram_waddr_o,
    output logic [TAG_W:0]      sram_wtag_o,
    output logic [LINE_W-1:0]   sram_wdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    input  logic                mem_rvalid_i,
    input  logic [LINE_W-1:0]   mem_rdata_i,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);

    localparam int WORD_W = OFFSET_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_RESP      = 3'd2,
        ST_MISS_REQ  = 3'd3,
        ST_FILL_WAIT = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                rsp_valid_r;
    logic [31:0]         rsp_data_r;
    logic                mem_req_valid_r;
    logic [ADDR_W-1:0]   mem_req_addr_r;
    logic [31:0]         hit_cnt_r;
    logic [31:0]         miss_cnt_r;

    logic [TAG_W-1:0]    tag_s;
    logic [INDEX_W-1:0]  index_s;
    logic [WORD_W-1:0]   word_s;
    logic [INDEX_W-1:0]  req_index_s;
    logic                hit_s;
    logic                unused_s;

    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                              input logic [WORD_W-1:0] sel);
        pick_word = line[{sel, 5'b00000} +: 32];
    endfunction

    assign tag_s       = addr_r[ADDR_W-1 -: TAG_W];
    assign index_s     = addr_r[OFFSET_W +: INDEX_W];
    assign word_s      = addr_r[OFFSET_W-1:2];
    assign req_index_s = req_addr_i[OFFSET_W +: INDEX_W];
    assign hit_s       = sram_rtag_i[TAG_W] && (sram_rtag_i[TAG_W-1:0] == tag_s);
    // Byte-within-word bits are latched with the address but never select anything.
    assign unused_s    = ^addr_r[1:0];

    assign rsp_valid_o     = rsp_valid_r;
    assign rsp_data_o      = rsp_data_r;
    assign mem_req_valid_o = mem_req_valid_r;
    assign mem_req_addr_o  = mem_req_addr_r;
    assign hit_cnt_o       = hit_cnt_r;
    assign miss_cnt_o      = miss_cnt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) state_s = ST_LOOKUP;
                else             state_s = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (hit_s) state_s = ST_RESP;
                else       state_s = ST_MISS_REQ;
            end
            ST_MISS_REQ: begin
                if (mem_req_ready_i) state_s = ST_FILL_WAIT;
                else                 state_s = ST_MISS_REQ;
            end
            ST_FILL_WAIT: begin
                if (mem_rvalid_i) state_s = ST_RESP;
                else              state_s = ST_FILL_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready_i) state_s = ST_IDLE;
                else             state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // SRAM strobes: reads only from IDLE, writes only from FILL_WAIT, so one index never sees both.
    always_comb begin
        req_ready_o  = 1'b0;
        sram_rden_o  = 1'b0;
        sram_raddr_o = {INDEX_W{1'b0}};
        sram_wren_o  = 1'b0;
        sram_waddr_o = {INDEX_W{1'b0}};
        sram_wtag_o  = {(TAG_W+1){1'b0}};
        sram_wdata_o = {LINE_W{1'b0}};
        if (rst_n && (state_r == ST_IDLE)) begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
                sram_rden_o  = 1'b1;
                sram_raddr_o = req_index_s;
            end else begin
                sram_rden_o  = 1'b0;
            end
        end else if (rst_n && (state_r == ST_FILL_WAIT) && mem_rvalid_i) begin
            sram_wren_o  = 1'b1;
            sram_waddr_o = index_s;
            sram_wtag_o  = {1'b1, tag_s};
            sram_wdata_o = mem_rdata_i;
        end else begin
            req_ready_o  = 1'b0;
        end
    end

    // Request latch, response/fetch registers and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r          <= {ADDR_W{1'b0}};
            rsp_valid_r     <= 1'b0;
            rsp_data_r      <= 32'h0000_0000;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            hit_cnt_r       <= 32'h0000_0000;
            miss_cnt_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) addr_r <= req_addr_i;
                end
                ST_LOOKUP: begin
                    if (hit_s) begin
                        rsp_data_r  <= pick_word(sram_rdata_i, word_s);
                        rsp_valid_r <= 1'b1;
                        if (hit_cnt_r != 32'hFFFF_FFFF) hit_cnt_r <= hit_cnt_r + 32'd1;
                    end else begin
                        mem_req_valid_r <= 1'b1;
                        mem_req_addr_r  <= {addr_r[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        if (miss_cnt_r != 32'hFFFF_FFFF) miss_cnt_r <= miss_cnt_r + 32'd1;
                    end
                end
                ST_MISS_REQ: begin
                    if (mem_req_ready_i) mem_req_valid_r <= 1'b0;
                end
                ST_FILL_WAIT: begin
                    if (mem_rvalid_i) begin
                        rsp_data_r  <= pick_word(mem_rdata_i, word_s);
                        rsp_valid_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        rsp_data_r  <= 32'h0000_0000;
                    end
                end
                default: begin
                    rsp_valid_r     <= 1'b0;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed bench for cache_lookup_ctrl: behavioural tag/data SRAM, table of read transactions
// with hand-computed results, plus hand-written stall and mid-fill reset sequences.
module tb_cache_lookup_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [31:0]  req_addr_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  rsp_data_o;
    logic         sram_rden_o;
    logic [8:0]   sram_raddr_o;
    logic [17:0]  sram_rtag_i;
    logic [511:0] sram_rdata_i;
    logic         sram_wren_o;
    logic [8:0]   sram_waddr_o;
    logic [17:0]  sram_wtag_o;
    logic [511:0] sram_wdata_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rvalid_i;
    logic [511:0] mem_rdata_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [511:0] line_a;
    logic [511:0] line_b;
    logic         sram_clr;
    logic [17:0]  tag_mem [512];
    logic [511:0] data_mem [512];

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [8:0]  idx;
        logic [17:0] wtag;
        logic [31:0] maddr;
        logic        use_b;
        logic [31:0] data;
        logic [31:0] hits;
        logic [31:0] misses;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    cache_lookup_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .sram_rden_o(sram_rden_o), .sram_raddr_o(sram_raddr_o),
        .sram_rtag_i(sram_rtag_i), .sram_rdata_i(sram_rdata_i),
        .sram_wren_o(sram_wren_o), .sram_waddr_o(sram_waddr_o),
        .sram_wtag_o(sram_wtag_o), .sram_wdata_o(sram_wdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    // Behavioural SRAM: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 512; i++) tag_mem[i] <= 18'h0_0000;
        end else if (sram_wren_o) begin
            tag_mem[sram_waddr_o]  <= sram_wtag_o;
            data_mem[sram_waddr_o] <= sram_wdata_o;
        end
        if (sram_rden_o) begin
            sram_rtag_i  <= tag_mem[sram_raddr_o];
            sram_rdata_i <= data_mem[sram_raddr_o];
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete read: request, lookup, optional refill, response handshake.
    task automatic run_read(input vec_t v);
        req_valid_i = 1'b1;
        req_addr_i  = v.addr;
        #1;
        chk("req_ready_idle", {511'd0, req_ready_o}, 512'd1);
        chk("sram_rden", {511'd0, sram_rden_o}, 512'd1);
        chk("sram_raddr", {503'd0, sram_raddr_o}, {503'd0, v.idx});
        step();
        req_valid_i = 1'b0;
        chk("req_ready_lookup", {511'd0, req_ready_o}, 512'd0);
        step();
        if (v.hit) begin
            chk("hit_rsp_valid_T2", {511'd0, rsp_valid_o}, 512'd1);
            chk("hit_no_mem_req", {511'd0, mem_req_valid_o}, 512'd0);
        end else begin
            chk("miss_mem_req_valid", {511'd0, mem_req_valid_o}, 512'd1);
            chk("miss_mem_req_addr", {480'd0, mem_req_addr_o}, {480'd0, v.maddr});
            chk("miss_no_rsp", {511'd0, rsp_valid_o}, 512'd0);
            mem_req_ready_i = 1'b1;
            step();
            mem_req_ready_i = 1'b0;
            chk("mem_req_dropped", {511'd0, mem_req_valid_o}, 512'd0);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.use_b ? line_b : line_a;
            #1;
            chk("fill_wren", {511'd0, sram_wren_o}, 512'd1);
            chk("fill_waddr", {503'd0, sram_waddr_o}, {503'd0, v.idx});
            chk("fill_wtag", {494'd0, sram_wtag_o}, {494'd0, v.wtag});
            chk("fill_wdata", sram_wdata_o, v.use_b ? line_b : line_a);
            step();
            mem_rvalid_i = 1'b0;
            chk("fill_wren_pulse", {511'd0, sram_wren_o}, 512'd0);
            chk("fill_rsp_valid", {511'd0, rsp_valid_o}, 512'd1);
        end
        chk("rsp_data", {480'd0, rsp_data_o}, {480'd0, v.data});
        chk("hit_cnt", {480'd0, hit_cnt_o}, {480'd0, v.hits});
        chk("miss_cnt", {480'd0, miss_cnt_o}, {480'd0, v.misses});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("rsp_cleared", {511'd0, rsp_valid_o}, 512'd0);
        chk("back_idle", {511'd0, req_ready_o}, 512'd1);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            line_a[32*i +: 32] = 32'hA000_0000 + 32'(i);
            line_b[32*i +: 32] = 32'hB000_0000 + 32'(i);
        end
        line_a[63:32]   = 32'hDEAD_BEEF;
        line_a[511:480] = 32'hCAFE_F00D;

        //            addr          hit   idx     wtag        maddr         b     data           hits  misses
        tbl[0] = '{32'h0000_1004, 1'b0, 9'h040, 18'h2_0000, 32'h0000_1000, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd1};
        tbl[1] = '{32'h0000_1004, 1'b1, 9'h040, 18'h0_0000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'd1, 32'd1};
        tbl[2] = '{32'h0000_9004, 1'b0, 9'h040, 18'h2_0001, 32'h0000_9000, 1'b1, 32'hB000_0001, 32'd1, 32'd2};
        tbl[3] = '{32'h0000_1004, 1'b0, 9'h040, 18'h2_0000, 32'h0000_1000, 1'b0, 32'hDEAD_BEEF, 32'd1, 32'd3};
        tbl[4] = '{32'h0000_103C, 1'b1, 9'h040, 18'h0_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 32'd2, 32'd3};
        tbl[5] = '{32'h0000_1000, 1'b1, 9'h040, 18'h0_0000, 32'h0000_0000, 1'b0, 32'hA000_0000, 32'd3, 32'd3};
        tbl[6] = '{32'h0000_2008, 1'b0, 9'h080, 18'h2_0000, 32'h0000_2000, 1'b1, 32'hB000_0002, 32'd3, 32'd4};
        tbl[7] = '{32'h0000_2008, 1'b1, 9'h080, 18'h0_0000, 32'h0000_0000, 1'b1, 32'hB000_0002, 32'd4, 32'd4};

        rst_n = 1'b0; sram_clr = 1'b1;
        req_valid_i = 1'b0; req_addr_i = 32'h0; rsp_ready_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 512'd0;
        repeat (3) step();
        rst_n = 1'b1; sram_clr = 1'b0;
        #1;
        chk("rst_rsp_valid", {511'd0, rsp_valid_o}, 512'd0);
        chk("rst_mem_req_valid", {511'd0, mem_req_valid_o}, 512'd0);
        chk("rst_mem_req_addr", {480'd0, mem_req_addr_o}, 512'd0);
        chk("rst_rsp_data", {480'd0, rsp_data_o}, 512'd0);
        chk("rst_wren", {511'd0, sram_wren_o}, 512'd0);
        chk("rst_rden", {511'd0, sram_rden_o}, 512'd0);
        chk("rst_counters", {448'd0, hit_cnt_o, miss_cnt_o}, 512'd0);
        chk("rst_req_ready", {511'd0, req_ready_o}, 512'd1);
        step();

        for (int i = 0; i < 8; i++) run_read(tbl[i]);

        // Response back-pressure on a hit: valid/data hold, no new request accepted.
        req_valid_i = 1'b1; req_addr_i = 32'h0000_1004;
        step();
        req_valid_i = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {511'd0, rsp_valid_o}, 512'd1);
            chk("stall_rsp_data", {480'd0, rsp_data_o}, {480'd0, 32'hDEAD_BEEF});
            chk("stall_req_ready", {511'd0, req_ready_o}, 512'd0);
            step();
        end
        chk("stall_hit_cnt", {480'd0, hit_cnt_o}, {480'd0, 32'd5});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("stall_released", {511'd0, rsp_valid_o}, 512'd0);

        // Memory back-pressure: fetch request and address hold, no SRAM write.
        req_valid_i = 1'b1; req_addr_i = 32'h0000_4010;
        step();
        req_valid_i = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("memstall_valid", {511'd0, mem_req_valid_o}, 512'd1);
            chk("memstall_addr", {480'd0, mem_req_addr_o}, {480'd0, 32'h0000_4000});
            chk("memstall_no_wren", {511'd0, sram_wren_o}, 512'd0);
            step();
        end
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = line_a;
        step();
        mem_rvalid_i = 1'b0;
        chk("memstall_rsp", {480'd0, rsp_data_o}, {480'd0, 32'hA000_0004});
        chk("memstall_miss_cnt", {480'd0, miss_cnt_o}, {480'd0, 32'd5});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Reset while waiting for the fill: late fill data must be ignored.
        req_valid_i = 1'b1; req_addr_i = 32'h0000_8000;
        step();
        req_valid_i = 1'b0;
        step();
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = line_b;
        #1;
        chk("midrst_no_wren", {511'd0, sram_wren_o}, 512'd0);
        chk("midrst_idle", {511'd0, req_ready_o}, 512'd1);
        chk("midrst_counters", {448'd0, hit_cnt_o, miss_cnt_o}, 512'd0);
        step();
        mem_rvalid_i = 1'b0;
        chk("midrst_no_rsp", {511'd0, rsp_valid_o}, 512'd0);
        v = '{32'h0000_8000, 1'b0, 9'h000, 18'h2_0001, 32'h0000_8000, 1'b1, 32'hB000_0000, 32'd0, 32'd1};
        run_read(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
